sram_controller: RTL

- Sequences every data-memory access from the Mem stage onto an external 16-bit asynchronous SRAM.
- Each 32-bit word is split into two halfword phases; each phase is held for a programmable number of wait cycles.
- Drives a `ready` handshake. The pipeline top ORs `~ready` into the freeze of every pipeline register, so the pipeline stalls while an access is in flight.

---
 rtl/sram_controller_pkg.sv | 25 ++
 rtl/sram_controller_if.sv | 28 ++
 rtl/sram_phase_counter.sv | 27 ++
 rtl/sram_controller.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared settings for the data-memory SRAM controller: bus widths, memory base
// and the phase state encoding.
package sram_controller_pkg;

    localparam int SRAM_DATA_WIDTH = 16;
    localparam int SRAM_ADDR_WIDTH = 18;
    localparam int WORD_ADDR_WIDTH = SRAM_ADDR_WIDTH - 1;
    localparam int DATA_MEM_BASE   = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_t;

    // Halfword address of one half of a 32-bit word.
    function automatic logic [SRAM_ADDR_WIDTH-1:0] half_addr(
        input logic [WORD_ADDR_WIDTH-1:0] word,
        input logic                       hi
    );
        return {word, hi};
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response signals plus the external SRAM pins.
interface sram_controller_if
    import sram_controller_pkg::*;
#(
    parameter int WORD_WIDTH = 32
);
    logic                       rd_en;
    logic                       wr_en;
    logic [WORD_WIDTH-1:0]      address;
    logic [WORD_WIDTH-1:0]      write_data;
    logic [WORD_WIDTH-1:0]      read_data;
    logic                       ready;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
    logic [SRAM_DATA_WIDTH-1:0] sram_dq_out;
    logic                       sram_dq_oe;
    logic [SRAM_DATA_WIDTH-1:0] sram_dq_in;
    logic                       sram_we_n;

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_phase_counter.sv
// Wait counter for one halfword phase; `last` marks the final held cycle.
module sram_phase_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);
    logic [3:0] count_r;

    // Count register: clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 4'd0;
        end else if (clear) begin
            count_r <= 4'd0;
        end else if (en) begin
            count_r <= count_r + 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign last = (count_r == 4'(WAIT_CYCLES - 1));
endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit Mem-stage access into two held halfword phases on a 16-bit
// asynchronous SRAM, stalling the pipeline through `ready`.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus
);
    sram_state_t                state_r;
    sram_state_t                state_s;
    logic [WORD_ADDR_WIDTH-1:0] word_r;
    logic [WORD_WIDTH-1:0]      wdata_r;
    logic                       is_write_r;
    logic [WORD_WIDTH-1:0]      rdata_r;
    logic                       req_s;
    logic                       last_s;
    logic                       cnt_clear_s;
    logic                       cnt_en_s;
    logic [WORD_WIDTH-1:0]      diff_s;
    logic [WORD_ADDR_WIDTH-1:0] word_s;
    logic                       unused_bits_s;

    assign req_s  = bus.rd_en | bus.wr_en;
    // Out-of-range addresses simply wrap inside the SRAM word space.
    assign diff_s = bus.address - WORD_WIDTH'(DATA_MEM_BASE);
    assign word_s = diff_s[SRAM_ADDR_WIDTH:2];
    assign unused_bits_s = ^{diff_s[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], diff_s[1:0]};

    assign cnt_clear_s = (state_r == ST_IDLE) | last_s;
    assign cnt_en_s    = (state_r == ST_LO) | (state_r == ST_HI);

    sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear_s),
        .en    (cnt_en_s),
        .last  (last_s)
    );

    // State, request capture and halfword read latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            word_r     <= '0;
            wdata_r    <= '0;
            is_write_r <= 1'b0;
            rdata_r    <= '0;
        end else begin
            state_r <= state_s;
            if ((state_r == ST_IDLE) && req_s) begin
                word_r     <= word_s;
                wdata_r    <= bus.write_data;
                is_write_r <= bus.wr_en;
            end
            if ((state_r == ST_LO) && last_s && !is_write_r) begin
                rdata_r[SRAM_DATA_WIDTH-1:0] <= bus.sram_dq_in;
            end
            if ((state_r == ST_HI) && last_s && !is_write_r) begin
                rdata_r[2*SRAM_DATA_WIDTH-1:SRAM_DATA_WIDTH] <= bus.sram_dq_in;
            end
        end
    end

    assign bus.read_data = rdata_r;

    // Next state and SRAM pin decode; we_n rises on the last cycle of each phase
    // so address and data are held past the write pulse.
    always_comb begin
        state_s         = state_r;
        bus.ready       = 1'b0;
        bus.sram_we_n   = 1'b1;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        case (state_r)
            ST_IDLE: begin
                bus.ready = ~req_s;
                if (req_s) begin
                    state_s = ST_LO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LO: begin
                bus.sram_addr = half_addr(word_r, 1'b0);
                if (is_write_r) begin
                    bus.sram_dq_out = wdata_r[SRAM_DATA_WIDTH-1:0];
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = last_s;
                end else begin
                    bus.sram_we_n   = 1'b1;
                end
                if (last_s) begin
                    state_s = ST_HI;
                end else begin
                    state_s = ST_LO;
                end
            end
            ST_HI: begin
                bus.sram_addr = half_addr(word_r, 1'b1);
                if (is_write_r) begin
                    bus.sram_dq_out = wdata_r[2*SRAM_DATA_WIDTH-1:SRAM_DATA_WIDTH];
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = last_s;
                end else begin
                    bus.sram_we_n   = 1'b1;
                end
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_HI;
                end
            end
            ST_DONE: begin
                bus.ready = 1'b1;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end
endmodule
